// File: rtl/ysyx_23060278_pipe_reg.sv
// ---------------------------------------------------------------------------
// ysyx_23060278_pipe_reg
// Pipeline register with a valid/ready handshake on both sides, a synchronous
// flush for redirects, and an optional two-entry skid buffer that removes the
// combinational out_ready -> in_ready path.
//
// Parameters
//   WIDTH     payload width in bits (>= 1)
//   RESET_VAL out_data value after reset and after flush
//   SKID      1: two-entry skid mode, in_ready is driven from a flop
//             0: single-entry mode, in_ready follows out_ready combinationally
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous reset, active low
//   flush      synchronous flush, drops every held entry
//   in_valid   upstream payload valid
//   in_ready   this stage can take a payload
//   in_data    upstream payload
//   out_valid  downstream payload valid (flop output)
//   out_ready  downstream takes the payload
//   out_data   downstream payload (flop output)
//   occ        number of held entries, 0..2 (flop output)
// ---------------------------------------------------------------------------
module ysyx_23060278_pipe_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               SKID      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occ
);

  localparam bit SKID_EN = (SKID != 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_nxt;
  logic             skid_valid;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Upstream ready: from the skid-valid flop in skid mode, else from out_ready.
  always_comb begin
    if (SKID_EN) begin
      in_ready = ~skid_valid & ~flush;
    end else begin
      in_ready = (~out_valid | out_ready) & ~flush;
    end
  end

  // Next-state and next-payload selection for the main and skid entries.
  always_comb begin
    state_nxt = state;
    data_nxt  = out_data;
    skid_nxt  = skid_data;
    if (flush) begin
      state_nxt = EMPTY;
      data_nxt  = RESET_VAL;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            data_nxt  = in_data;
            state_nxt = FULL1;
          end else begin
            state_nxt = EMPTY;
          end
        end
        FULL1: begin
          if (in_fire && out_fire) begin
            data_nxt = in_data;
          end else if (in_fire) begin
            // Only reachable in skid mode: single-entry mode never accepts
            // while the held payload is stalled.
            skid_nxt  = in_data;
            state_nxt = FULL2;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end else begin
            state_nxt = FULL1;
          end
        end
        FULL2: begin
          if (out_fire) begin
            data_nxt  = skid_data;
            state_nxt = FULL1;
          end else begin
            state_nxt = FULL2;
          end
        end
        default: begin
          // Unused encoding: recover to a clean empty stage.
          state_nxt = EMPTY;
          data_nxt  = RESET_VAL;
        end
      endcase
    end
  end

  // State, payload and decoded status flops; status is registered so every
  // output except in_ready comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= EMPTY;
      out_data   <= RESET_VAL;
      skid_data  <= {WIDTH{1'b0}};
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      occ        <= 2'd0;
    end else begin
      state      <= state_nxt;
      out_data   <= data_nxt;
      skid_data  <= skid_nxt;
      out_valid  <= (state_nxt != EMPTY);
      skid_valid <= (state_nxt == FULL2);
      occ        <= state_nxt;
    end
  end

endmodule

// File: tb/tb_ysyx_23060278_pipe_reg.sv
// ---------------------------------------------------------------------------
// Bench for ysyx_23060278_pipe_reg. Two instances (skid and single-entry)
// share the same stimulus; each is compared against its own queue model:
// a FIFO of capacity 2 (skid) or 1 (single entry) plus the last value shown.
// ---------------------------------------------------------------------------
module tb_ysyx_23060278_pipe_reg;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        flush = 1'b0;
  logic        iv    = 1'b0;
  logic [31:0] id    = 32'd0;
  logic        ordy  = 1'b0;

  logic        ir1, ov1, ir0, ov0;
  logic [31:0] od1, od0;
  logic [1:0]  occ1, occ0;

  int total  = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] shown1 = 32'd0;
  logic [31:0] shown0 = 32'd0;

  ysyx_23060278_pipe_reg #(.WIDTH(32), .RESET_VAL(32'd0), .SKID(1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv), .in_ready(ir1), .in_data(id),
    .out_valid(ov1), .out_ready(ordy), .out_data(od1), .occ(occ1)
  );

  ysyx_23060278_pipe_reg #(.WIDTH(32), .RESET_VAL(32'd0), .SKID(0)) dut_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(iv), .in_ready(ir0), .in_data(id),
    .out_valid(ov0), .out_ready(ordy), .out_data(od0), .occ(occ0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    check({where, ":out_valid_skid"}, {31'd0, ov1}, (q1.size() != 0) ? 32'd1 : 32'd0);
    check({where, ":occ_skid"}, {30'd0, occ1}, 32'(q1.size()));
    check({where, ":out_data_skid"}, od1, shown1);
    check({where, ":out_valid_single"}, {31'd0, ov0}, (q0.size() != 0) ? 32'd1 : 32'd0);
    check({where, ":occ_single"}, {30'd0, occ0}, 32'(q0.size()));
    check({where, ":out_data_single"}, od0, shown0);
  endtask

  task automatic model_reset();
    q1.delete();
    q0.delete();
    shown1 = 32'd0;
    shown0 = 32'd0;
  endtask

  // One clock: drive at posedge+1, check in_ready before the edge, advance
  // the models at the edge, check registered outputs at posedge+1.
  task automatic cycle(input string where, input logic v, input logic [31:0] d,
                       input logic r, input logic f);
    bit ir1e, ir0e, of1, of0;
    iv = v; id = d; ordy = r; flush = f;
    #3;
    ir1e = (q1.size() < 2) && !f;
    ir0e = (q0.size() == 0 || r) && !f;
    check({where, ":in_ready_skid"}, {31'd0, ir1}, {31'd0, ir1e});
    check({where, ":in_ready_single"}, {31'd0, ir0}, {31'd0, ir0e});
    of1 = (q1.size() != 0) && r;
    of0 = (q0.size() != 0) && r;
    @(posedge clk);
    if (f) begin
      model_reset();
    end else begin
      if (of1) void'(q1.pop_front());
      if (v && ir1e) q1.push_back(d);
      if (q1.size() != 0) shown1 = q1[0];
      if (of0) void'(q0.pop_front());
      if (v && ir0e) q0.push_back(d);
      if (q0.size() != 0) shown0 = q0[0];
    end
    #1;
    check_outputs(where);
  endtask

  initial begin
    // Reset with a payload offered: nothing may be taken.
    iv = 1'b1; id = 32'hDEADBEEF;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    check("reset:in_ready_skid", {31'd0, ir1}, 32'd1);
    check("reset:in_ready_single", {31'd0, ir0}, 32'd1);
    @(posedge clk);
    #1;
    check_outputs("reset_edge");
    rst = 1'b1;

    cycle("first", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle("first_drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // Streaming with continuous readiness.
    for (int k = 1; k <= 8; k++) cycle("stream", 1'b1, 32'(k), 1'b1, 1'b0);
    cycle("stream_drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure: fill, offer a third while full, then drain.
    cycle("bp_a", 1'b1, 32'hA, 1'b0, 1'b0);
    cycle("bp_b", 1'b1, 32'hB, 1'b0, 1'b0);
    cycle("bp_c", 1'b1, 32'hC, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle("bp_drain", 1'b0, 32'd0, 1'b1, 1'b0);

    // Single-entry replacement in the same cycle as consumption.
    cycle("rep_a", 1'b1, 32'h11, 1'b0, 1'b0);
    cycle("rep_b", 1'b1, 32'h22, 1'b1, 1'b0);
    cycle("rep_drain", 1'b0, 32'd0, 1'b1, 1'b0);
    cycle("rep_drain2", 1'b0, 32'd0, 1'b1, 1'b0);

    // Flush while full with a payload offered.
    cycle("fl_a", 1'b1, 32'hA, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 32'hB, 1'b0, 1'b0);
    cycle("flush", 1'b1, 32'hC, 1'b0, 1'b1);
    cycle("after_flush", 1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int k = 0; k < 200; k++) begin
      cycle("rand", 1'($urandom_range(1)), $urandom, 1'($urandom_range(1)),
            ($urandom_range(15) == 0));
    end

    // Asynchronous reset between edges while the skid instance holds two.
    cycle("ar_drain", 1'b0, 32'd0, 1'b1, 1'b0);
    cycle("ar_drain2", 1'b0, 32'd0, 1'b1, 1'b0);
    cycle("ar_a", 1'b1, 32'h5A, 1'b0, 1'b0);
    cycle("ar_b", 1'b1, 32'h5B, 1'b0, 1'b0);
    check("ar_pre:occ_skid", {30'd0, occ1}, 32'd2);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    check("async_reset:in_ready_skid", {31'd0, ir1}, 32'd1);
    @(posedge clk);
    #1;
    check_outputs("async_reset_edge");
    rst = 1'b1;
    for (int k = 1; k <= 4; k++) cycle("restart", 1'b1, 32'(32'h100 + k), 1'b1, 1'b0);
    cycle("restart_drain", 1'b0, 32'd0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
